// File: rtl/rob_commit_pkg.sv
// Shared sizing, entry layout and constants for the reorder buffer.
package rob_commit_pkg;
  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned CNT_W     = TAG_W + 1;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned XLEN      = 32;

  localparam logic [CNT_W-1:0] ROB_FULL = CNT_W'(ROB_DEPTH);
  localparam logic [XLEN-1:0]  NULL32   = '0;

  typedef struct packed {
    logic             busy;
    logic             ready;
    logic             wr;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  val;
    logic             jump;
    logic [XLEN-1:0]  pc;
  } rob_entry_t;
endpackage

// File: rtl/rob_commit.sv
// 16-entry circular reorder buffer: in-order allocate, CDB capture,
// operand lookup with CDB bypass, in-order retire and mispredict flush.
module rob_commit
  import rob_commit_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rdy,
  input  logic             i_iss_valid,
  input  logic             i_iss_wr,
  input  logic [REG_W-1:0] i_iss_rd,
  output logic             o_iss_ready,
  output logic [TAG_W-1:0] o_iss_tag,
  output logic             o_rf_in_flag,
  output logic [REG_W-1:0] o_rf_in_a,
  output logic [TAG_W-1:0] o_rf_in_rob,
  output logic             o_rf_out_flag,
  output logic [REG_W-1:0] o_rf_out_a,
  output logic [XLEN-1:0]  o_rf_out_val,
  output logic [TAG_W-1:0] o_rf_out_rob,
  input  logic             i_cdb_valid,
  input  logic [TAG_W-1:0] i_cdb_tag,
  input  logic [XLEN-1:0]  i_cdb_val,
  input  logic             i_cdb_jump,
  input  logic [XLEN-1:0]  i_cdb_pc,
  input  logic [TAG_W-1:0] i_q1_tag,
  input  logic [TAG_W-1:0] i_q2_tag,
  output logic             o_q1_ready,
  output logic             o_q2_ready,
  output logic [XLEN-1:0]  o_q1_val,
  output logic [XLEN-1:0]  o_q2_val,
  output logic             o_flush,
  output logic [XLEN-1:0]  o_flush_pc
);

  rob_entry_t       r_ent [ROB_DEPTH];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  rob_entry_t w_head_ent;
  logic       w_commit;
  logic       w_flush;
  logic       w_issue;
  logic       w_cdb_wr;
  logic       w_q1_hit;
  logic       w_q2_hit;

  assign w_head_ent = r_ent[r_head];
  assign w_commit   = i_rdy & (r_count != '0) & w_head_ent.ready;
  assign w_flush    = w_commit & w_head_ent.jump;
  assign w_issue    = i_rdy & i_iss_valid & o_iss_ready;
  assign w_cdb_wr   = i_rdy & i_cdb_valid & r_ent[i_cdb_tag].busy;

  assign o_iss_ready  = (r_count != ROB_FULL) & ~w_flush;
  assign o_iss_tag    = r_tail;
  assign o_rf_in_flag = w_issue & i_iss_wr & (i_iss_rd != '0);
  assign o_rf_in_a    = i_iss_rd;
  assign o_rf_in_rob  = r_tail;

  assign o_rf_out_flag = w_commit & w_head_ent.wr & (w_head_ent.rd != '0);
  assign o_rf_out_a    = w_head_ent.rd;
  assign o_rf_out_val  = w_head_ent.val;
  assign o_rf_out_rob  = r_head;

  assign o_flush    = w_flush;
  assign o_flush_pc = w_flush ? w_head_ent.pc : NULL32;

  // A result on the CDB this cycle is forwarded even before it lands in the entry.
  assign w_q1_hit   = i_cdb_valid & (i_cdb_tag == i_q1_tag);
  assign w_q2_hit   = i_cdb_valid & (i_cdb_tag == i_q2_tag);
  assign o_q1_ready = (r_ent[i_q1_tag].busy & r_ent[i_q1_tag].ready) | w_q1_hit;
  assign o_q2_ready = (r_ent[i_q2_tag].busy & r_ent[i_q2_tag].ready) | w_q2_hit;
  assign o_q1_val   = w_q1_hit ? i_cdb_val : r_ent[i_q1_tag].val;
  assign o_q2_val   = w_q2_hit ? i_cdb_val : r_ent[i_q2_tag].val;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) r_ent[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) r_ent[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Tail is never busy when issue fires, so issue and CDB never target one entry.
      if (w_cdb_wr) begin
        r_ent[i_cdb_tag].ready <= 1'b1;
        r_ent[i_cdb_tag].val   <= i_cdb_val;
        r_ent[i_cdb_tag].jump  <= i_cdb_jump;
        r_ent[i_cdb_tag].pc    <= i_cdb_pc;
      end
      if (w_commit) begin
        r_ent[r_head].busy <= 1'b0;
        r_head             <= r_head + 1'b1;
      end
      if (w_issue) begin
        r_ent[r_tail].busy  <= 1'b1;
        r_ent[r_tail].ready <= 1'b0;
        r_ent[r_tail].wr    <= i_iss_wr;
        r_ent[r_tail].rd    <= i_iss_rd;
        r_ent[r_tail].val   <= NULL32;
        r_ent[r_tail].jump  <= 1'b0;
        r_ent[r_tail].pc    <= NULL32;
        r_tail              <= r_tail + 1'b1;
      end
      unique case ({w_issue, w_commit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
